// File: rtl/sim_debug_port.sv
// Memory-mapped debug console: buffers firmware characters in a FIFO, sends
// them as 8N1 UART frames on tx, and latches an end-of-test exit code.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cs, we, addr, wdata bus access (addr 0 DATA, 1 STATUS, 2 EXIT, 3 reserved)
//   rdata               registered read data (1-cycle latency)
//   tx                  UART serial output, idle high
//   halted, exit_code   set by the first EXIT write after reset
//   busy                FIFO non-empty or a frame in progress
module sim_debug_port #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        halted,
  output logic [15:0] exit_code,
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          ovf;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_nx;
  logic [2:0]    bitn;
  logic [2:0]    bitn_nx;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nx;
  logic          tx_nx;

  logic empty_c;
  logic full_c;
  logic bit_end_c;
  logic pop_c;
  logic push_c;
  logic drop_c;
  logic data_wr_c;
  logic tx_active_c;

  assign empty_c     = (count == '0);
  assign full_c      = (count == CW'(FIFO_DEPTH));
  assign bit_end_c   = (baud == BW'(CLKS_PER_BIT - 1));
  assign tx_active_c = (state != S_IDLE);

  // DATA writes are ignored once halted; a full FIFO still accepts when a pop frees a slot
  assign data_wr_c = cs && we && (addr == 2'd0) && !halted;
  assign push_c    = data_wr_c && (!full_c || pop_c);
  assign drop_c    = data_wr_c && full_c && !pop_c;

  // TX next-state, pop request and next serial level
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bitn_nx  = bitn;
    shreg_nx = shreg;
    pop_c    = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nx = '0;
        bitn_nx = '0;
        if (!empty_c) begin
          pop_c    = 1'b1;
          shreg_nx = mem[rptr];
          state_nx = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          baud_nx  = '0;
          state_nx = S_DATA;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          baud_nx  = '0;
          shreg_nx = {1'b0, shreg[7:1]};
          if (bitn == 3'd7) begin
            bitn_nx  = '0;
            state_nx = S_STOP;
          end else begin
            bitn_nx = bitn + 3'd1;
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          baud_nx = '0;
          // chain straight into the next frame with no idle cycle
          if (!empty_c) begin
            pop_c    = 1'b1;
            shreg_nx = mem[rptr];
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase

    count_nx = count;
    if (push_c && !pop_c) begin
      count_nx = count + 1'b1;
    end else if (pop_c && !push_c) begin
      count_nx = count - 1'b1;
    end
  end

  // FIFO storage (no reset needed; occupancy tracked by count)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wptr] <= wdata[7:0];
    end
  end

  // State, FIFO pointers, registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud      <= '0;
      bitn      <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      halted    <= 1'b0;
      exit_code <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nx;
      baud  <= baud_nx;
      bitn  <= bitn_nx;
      shreg <= shreg_nx;
      tx    <= tx_nx;
      busy  <= (state_nx != S_IDLE) || (count_nx != '0);
      count <= count_nx;
      if (push_c) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_c) begin
        rptr <= rptr + 1'b1;
      end

      if (drop_c) begin
        ovf <= 1'b1;
      end else if (cs && we && (addr == 2'd1) && wdata[3]) begin
        ovf <= 1'b0;
      end

      if (cs && we && (addr == 2'd2) && !halted) begin
        halted    <= 1'b1;
        exit_code <= wdata;
      end

      if (cs && !we) begin
        case (addr)
          2'd1:    rdata <= {8'h00, 4'(count), ovf, tx_active_c, full_c, empty_c};
          2'd2:    rdata <= exit_code;
          default: rdata <= '0;
        endcase
      end
    end
  end

endmodule
